// File: rtl/direction_pkg.sv
// Shared direction codes, key bit positions and the fixed-priority encoder
// used by the direction driver.
package direction_pkg;

    localparam int DIR_W = 3;

    localparam logic [DIR_W-1:0] DIR_NONE  = 3'd0;
    localparam logic [DIR_W-1:0] DIR_UP    = 3'd1;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 3'd2;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 3'd3;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 3'd4;

    localparam int NUM_KEYS  = 4;
    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;

    // UP > DOWN > LEFT > RIGHT; nothing pressed gives DIR_NONE
    function automatic logic [DIR_W-1:0] encode_dir(input logic [NUM_KEYS-1:0] keys);
        logic [DIR_W-1:0] code;
        code = DIR_NONE;
        if (keys[KEY_UP])
            code = DIR_UP;
        else if (keys[KEY_DOWN])
            code = DIR_DOWN;
        else if (keys[KEY_LEFT])
            code = DIR_LEFT;
        else if (keys[KEY_RIGHT])
            code = DIR_RIGHT;
        return code;
    endfunction

endpackage

// File: rtl/direction_driver_if.sv
// Button/game-over inputs and direction code output of the direction driver.
// master = board/game side, slave = direction_driver.
interface direction_driver_if;
    import direction_pkg::*;

    logic             I_up;
    logic             I_down;
    logic             I_left;
    logic             I_right;
    logic             O_gameover;
    logic [DIR_W-1:0] dir_index;

    modport master (
        output I_up,
        output I_down,
        output I_left,
        output I_right,
        output O_gameover,
        input  dir_index
    );

    modport slave (
        input  I_up,
        input  I_down,
        input  I_left,
        input  I_right,
        input  O_gameover,
        output dir_index
    );

endinterface

// File: rtl/key_debouncer.sv
// One push-button: SYNC_STAGES-deep synchroniser followed by a counter that
// flips the debounced level only after DEBOUNCE_CYCLES consecutive differing cycles.
module key_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   level_reg;
    logic                   key_sync;

    assign key_sync  = sync_reg[SYNC_STAGES-1];
    assign key_level = level_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg  <= '0;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], key_raw};
            if (key_sync == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                // Held different for the full window: accept the new level
                level_reg <= ~level_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/direction_driver.sv
// Debounced push-buttons to a registered 3-bit direction code with game-over lockout.
// Define DIR_ONESHOT_EN for one-cycle pulses on key press instead of level output.
module direction_driver
    import direction_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic              I_clk,
    input  logic              I_rst,
    direction_driver_if.slave bus
);

    logic [NUM_KEYS-1:0] raw_keys;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] enc_src;
    logic [DIR_W-1:0]    dir_reg;

    assign raw_keys[KEY_UP]    = bus.I_up;
    assign raw_keys[KEY_DOWN]  = bus.I_down;
    assign raw_keys[KEY_LEFT]  = bus.I_left;
    assign raw_keys[KEY_RIGHT] = bus.I_right;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debouncer #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debouncer (
                .clk      (I_clk),
                .rst      (I_rst),
                .key_raw  (raw_keys[gi]),
                .key_level(key_level[gi])
            );
        end
    endgenerate

`ifdef DIR_ONESHOT_EN
    // Edge history keeps tracking during game-over so presses made then are dropped
    logic [NUM_KEYS-1:0] level_prev_reg;

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst)
            level_prev_reg <= '0;
        else
            level_prev_reg <= key_level;
    end

    assign enc_src = key_level & ~level_prev_reg;
`else
    assign enc_src = key_level;
`endif

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst)
            dir_reg <= DIR_NONE;
        else if (bus.O_gameover)
            dir_reg <= DIR_NONE;
        else
            dir_reg <= encode_dir(enc_src);
    end

    assign bus.dir_index = dir_reg;

endmodule

// File: tb/tb_direction_driver.sv
// Directed bench for direction_driver (DEBOUNCE_CYCLES=4, SYNC_STAGES=2): a
// cycle model checked on every falling edge plus hand-computed spot checks.
module tb_direction_driver;

    localparam int S = 2;
    localparam int D = 4;
`ifdef DIR_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    direction_driver_if bus ();

    direction_driver #(
        .DEBOUNCE_CYCLES(D),
        .SYNC_STAGES    (S)
    ) dut (
        .I_clk(clk),
        .I_rst(rst),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: raw keys delayed S cycles, a key's pressed state changes once the
    // delayed value has disagreed with it for D cycles in a row, output is the
    // priority code one cycle later (or a rising-edge code in one-shot mode).
    logic       m_hist [4][S];
    int         m_run  [4];
    logic       m_deb  [4];
    logic       m_prev [4];
    logic [2:0] m_dir;
    logic [3:0] m_raw;
    int         m_best;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                for (int i = 0; i < S; i++) m_hist[k][i] = 1'b0;
                m_run[k]  = 0;
                m_deb[k]  = 1'b0;
                m_prev[k] = 1'b0;
            end
            m_dir = 3'd0;
        end else begin
            m_raw  = {bus.I_right, bus.I_left, bus.I_down, bus.I_up};
            m_best = 0;
            for (int k = 3; k >= 0; k--) begin
                if (ONESHOT ? (m_deb[k] && !m_prev[k]) : m_deb[k]) m_best = k + 1;
            end
            m_dir = bus.O_gameover ? 3'd0 : 3'(m_best);
            for (int k = 0; k < 4; k++) begin
                m_prev[k] = m_deb[k];
                if (m_hist[k][S-1] != m_deb[k]) m_run[k]++;
                else m_run[k] = 0;
                if (m_run[k] == D) begin
                    m_deb[k] = !m_deb[k];
                    m_run[k] = 0;
                end
                for (int i = S - 1; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
                m_hist[k][0] = m_raw[k];
            end
        end
    end

    always @(negedge clk) begin
        compared++;
        if (bus.dir_index !== m_dir) begin
            mismatched++;
            $display("FAIL model t=%0t: dir_index=%0d expected %0d", $time, bus.dir_index, m_dir);
        end
    end

    task automatic check(input string name, input logic [2:0] exp);
        compared++;
        if (bus.dir_index !== exp) begin
            mismatched++;
            $display("FAIL %s t=%0t: dir_index=%0d expected %0d", name, $time, bus.dir_index, exp);
        end else begin
            $display("check %s t=%0t: dir_index=%0d ok", name, $time, bus.dir_index);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic keys(input logic u, input logic d, input logic l, input logic r);
        bus.I_up    = u;
        bus.I_down  = d;
        bus.I_left  = l;
        bus.I_right = r;
    endtask

    task automatic step(input logic u, input logic d, input logic l, input logic r,
                        input logic [2:0] code, input string name);
        keys(u, d, l, r);
        tick(7);
        check(name, code);
        tick(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 1'b1;
        keys(0, 0, 0, 0);
        bus.O_gameover = 1'b0;
        tick(3);
        check("reset_state", 3'd0);
        rst = 1'b0;
        tick(3);

        // All keys held, then an asynchronous mid-cycle reset pulse
        keys(1, 1, 1, 1);
        tick(10);
        check("all_keys", ONESHOT ? 3'd0 : 3'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("rst_async", 3'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(6);
        check("rst_hold", 3'd0);
        tick(1);
        check("rst_release", 3'd1);
        keys(0, 0, 0, 0);
        tick(10);
        check("all_released", 3'd0);

        // Up, down, right, left in turn
        keys(1, 0, 0, 0);
        tick(6);
        check("up_early", 3'd0);
        tick(1);
        check("up", 3'd1);
        tick(3);
        step(0, 1, 0, 0, 3'd2, "down");
        step(0, 0, 0, 1, 3'd4, "right");
        step(0, 0, 1, 0, 3'd3, "left");
        keys(0, 0, 0, 0);
        tick(10);

        // Short glitch is rejected
        keys(0, 0, 1, 0);
        tick(3);
        keys(0, 0, 0, 0);
        tick(10);
        check("glitch", 3'd0);

        // Simultaneous left+down, then down released
        step(0, 1, 1, 0, 3'd2, "prio_down");
        keys(0, 0, 1, 0);
        tick(7);
        check("prio_left", ONESHOT ? 3'd0 : 3'd3);

        // Game-over lockout with left still held
        bus.O_gameover = 1'b1;
        tick(1);
        check("go_force", 3'd0);
        tick(5);
        check("go_hold", 3'd0);
        bus.O_gameover = 1'b0;
        tick(1);
        check("go_resume", ONESHOT ? 3'd0 : 3'd3);
        keys(0, 0, 0, 0);
        tick(10);

        // Press that completes during game-over
        bus.O_gameover = 1'b1;
        keys(1, 0, 0, 0);
        tick(10);
        check("go_during", 3'd0);
        bus.O_gameover = 1'b0;
        tick(1);
        check("go_discard", ONESHOT ? 3'd0 : 3'd1);
        tick(2);
        keys(0, 0, 0, 0);
        tick(10);

        // Long hold of up
        keys(1, 0, 0, 0);
        tick(7);
        check("hold_first", 3'd1);
        tick(1);
        check("hold_next", ONESHOT ? 3'd0 : 3'd1);
        tick(12);
        check("hold_end", ONESHOT ? 3'd0 : 3'd1);
        keys(0, 0, 0, 0);
        tick(10);
        check("idle", 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/direction_driver.md
Name:
direction_driver

Overview:
- Converts four raw push-button inputs (up/down/left/right) into a registered 3-bit direction code for the game-control logic.
- Sits between the board buttons and the puzzle-move logic.
- Provides synchronisation, debouncing, fixed-priority encoding and a game-over lockout.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable clock cycles a synchronised key must hold before its debounced level changes (10 ms at 100 MHz); legal range 1 to 2^24-1.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser; minimum 2.

Ports:
- I_clk  input  1  system clock, rising-edge.
- I_rst  input  1  asynchronous, active-high reset.
- I_up  input  1  raw up key, active-high, asynchronous to I_clk.
- I_down  input  1  raw down key, active-high, asynchronous.
- I_left  input  1  raw left key, active-high, asynchronous.
- I_right  input  1  raw right key, active-high, asynchronous.
- O_gameover  input  1  game-over flag from game logic, synchronous to I_clk, active-high. The name is kept for codebase consistency even though this port is an input.
- dir_index  output  3  registered direction code.

Behaviour:
- Interface: one clock (I_clk); reset I_rst is asynchronous and active-high.
- Direction codes:
  - 3'd0 NONE
  - 3'd1 UP
  - 3'd2 DOWN
  - 3'd3 LEFT
  - 3'd4 RIGHT
  - Codes 5 to 7 are never driven.
- Reset: I_rst high clears immediately (asynchronously):
  - all synchroniser flops, debounce counters and debounced levels to 0;
  - dir_index to 0.
- Synchronisation: each raw key passes through a SYNC_STAGES flop chain.
- Debounce, per key:
  - The counter resets to 0 whenever the synchronised level equals the debounced level.
  - Otherwise it increments each cycle.
  - When the count reaches DEBOUNCE_CYCLES-1 while the level still differs, the debounced level flips on that edge and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is rejected.
- Encoding: combinational fixed priority over the debounced levels, UP > DOWN > LEFT > RIGHT. Multiple pressed keys yield the highest-priority code; no keys pressed yields 0.
- Output register: dir_index loads the encoded value each edge.
- Total latency from a raw edge to dir_index is SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles, which is 7 cycles with SYNC_STAGES=2 and DEBOUNCE_CYCLES=4.
- Default (level) mode: dir_index holds the code for as long as the debounced key remains pressed, then returns to 0 after release debounce.
- Game-over:
  - While O_gameover is 1, dir_index is forced to 0 on the next edge and stays 0.
  - Debouncers keep running during game-over.
  - When O_gameover falls, dir_index resumes normal encoding on the next edge; in level mode, a still-held key reappears.
- Reset asserted mid-debounce aborts the debounce. After release, keys must again be stable for the full debounce period.

Optional Feature:
- Macro DIR_ONESHOT_EN.
- Defined:
  - dir_index pulses the code for exactly one cycle when a debounced key transitions from 0 to 1, then returns to 0.
  - Holding a key produces no repeats.
  - If several keys become pressed on the same cycle, the highest-priority one wins.
  - A rising edge that occurs while O_gameover=1 is discarded and is not replayed after game-over clears.
- Not defined: level mode as described above.

Decomposition:
- Package direction_pkg holds:
  - localparams DIR_NONE=3'd0, DIR_UP=3'd1, DIR_DOWN=3'd2, DIR_LEFT=3'd3, DIR_RIGHT=3'd4;
  - DIR_W=3.
- One sub-module, key_debouncer, contains the synchroniser plus debounce counter, with parameters SYNC_STAGES and DEBOUNCE_CYCLES. It is instantiated four times.
- Priority encoding, game-over gating and the optional one-shot edge detection live in the top level.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset: I_rst pulsed high mid-cycle with all keys high -> dir_index=0 immediately; 0 stays until 7 cycles after I_rst falls, then becomes 1.
- Sequence: up held 10 cycles, then down 10, then right 10, then left 10 -> dir_index steps 1, 2, 4, 3, each code appearing 7 cycles after its key press (with 0 between codes when key presses do not overlap).
- Glitch: I_left high for 3 cycles only -> dir_index stays 0.
- Priority: I_left and I_down pressed simultaneously -> dir_index=2. Then down released -> dir_index=3 after release debounce.
- Game-over: I_left held, O_gameover=1 -> dir_index=0 on the next edge and held. O_gameover=0 -> dir_index=3 on the next edge in level mode; stays 0 with DIR_ONESHOT_EN.
- One-shot (DIR_ONESHOT_EN defined): I_up held 20 cycles -> dir_index=1 for exactly one cycle, then 0 for the rest of the hold.
